trig_seq_8p: RTL and testbench
==============================

Name: trig_seq_8p

Overview:
- Programmable trigger sequencer placed directly upstream of the 8-entry 32-channel code table.
- On a start event it loads the table's step index, then issues up to 8 trigger pulses. Each pulse has a host-programmed high time and a common low gap.
- While each pulse is high, the table presents one stored 32-bit code.
- Host programs durations, gap and step count over a flag/data write interface in the same style as the table's.

Parameters:
- DUR_W, 32, width of per-step high-time and gap counters, in clock cycles.
- NSTEP_MAX, 8, number of step slots; fixed to match the code table depth.

Ports:
- iClk  input  1  system clock.
- iRst  input  1  reset, asynchronous, active-low.
- iSET_DUR_FLAG  input  1  1-cycle write strobe: iSET_DUR goes to slot iSET_STEP.
- iSET_STEP  input  3  slot address for duration writes.
- iSET_DUR  input  DUR_W  trigger high time for the addressed step, in cycles.
- iSET_GAP_FLAG  input  1  1-cycle write strobe for iSET_GAP.
- iSET_GAP  input  DUR_W  trigger low time between steps, in cycles.
- iSET_NSTEP_FLAG  input  1  1-cycle write strobe for iSET_NSTEP.
- iSET_NSTEP  input  4  number of steps per run, 1..8.
- iStart  input  1  asynchronous external start; rising edge starts a run.
- iAbort  input  1  synchronous abort, level, sampled each clock.
- oIndexFlag  output  1  index-load strobe to the code table (its iSET_INDEX_FLAG).
- oIndex  output  8  index value to the code table (its iSET_INDEX).
- oTrigger  output  1  trigger to the code table (its iTrigger).
- oStep  output  3  slot number currently being played.
- oBusy  output  1  high from LOAD through the last gap.
- oDone  output  1  1-cycle pulse at normal run completion.

Behaviour:
- Reset (iRst low, async): FSM to IDLE; all outputs 0; durations 1; gap 1; nstep 8; synchronizer flops 0.
- Register writes are accepted only in IDLE; writes while oBusy=1 are dropped.
  - iSET_DUR=0 is stored as 1; iSET_GAP=0 is stored as 1. A falling edge between triggers is mandatory, because the table decrements on trigger fall.
  - iSET_NSTEP=0 is ignored (old value kept); values above 8 are clamped to 8.
- iStart: passes through a 2-flop synchronizer plus a third flop for edge detect.
  - A start edge in IDLE enters LOAD on the 3rd rising iClk after iStart is first sampled high.
  - Start edges outside IDLE are ignored; they are not queued.
- FSM, all outputs registered:
  - IDLE: oBusy=0. Go to LOAD on a start edge.
  - LOAD (1 cycle): oIndexFlag=1, oIndex=nstep-1, oBusy=1, step counter k=0.
  - SETTLE (1 cycle): oIndexFlag=0. The table commits the index on the falling flag, so no trigger may overlap the flag.
  - ON: oTrigger=1, oStep=nstep-1-k, for exactly dur[nstep-1-k] cycles.
    - If k==nstep-1, go to TAIL; else go to OFF.
  - OFF: oTrigger=0 for exactly gap cycles, then k=k+1 and return to ON.
  - TAIL (1 cycle): oTrigger=0, oBusy=0, oDone=1, then IDLE.
- Step order: slots are played from nstep-1 down to 0, matching the table's decrement-on-trigger index order. Duration slot s pairs with code slot s.
- Counters: one down-counter of DUR_W bits, reloaded on each ON/OFF entry. No wrap occurs because the minimum load is 1.
- iAbort=1 in any non-IDLE state: next cycle oTrigger=0, oIndexFlag=0, oBusy=0, state IDLE; oDone is not pulsed.
  - iAbort has priority over a start edge in the same cycle.
- Reset mid-run: outputs drop to 0 immediately (async); the code table index is left as-is.
- oIndex[7:3] is always 0.

Test Plan:
- Reset with nstep=8, dur=1, gap=1, then start edge -> oIndexFlag 1 cycle with oIndex=7, 1 idle cycle, 8 single-cycle trigger pulses separated by 1-cycle gaps, oStep 7..0, oDone after the last pulse; total oBusy=17 cycles.
- nstep=3, dur[2]=5, dur[1]=2, dur[0]=4, gap=3 -> oIndex=2; trigger high 5, low 3, high 2, low 3, high 4 cycles; oStep 2,1,0; oDone 1 cycle later.
- Write iSET_DUR=0 to slot 0 and iSET_NSTEP=0, then run -> slot 0 pulse is 1 cycle; nstep is unchanged from its previous value.
- Second start edge plus register writes during a run -> run timing unchanged; new values are not applied; no second run starts.
- iAbort asserted during the 2nd ON of a 4-step run -> oTrigger and oBusy low next cycle, no oDone; a following start edge runs all 4 steps normally from oIndex=3.
- iRst pulsed low mid-OFF -> all outputs 0 asynchronously; after release, registers are at defaults (nstep=8, dur=1, gap=1).

Source files
------------

// File: rtl/trig_seq_8p_if.sv
// Host/table-side signal bundle for the trigger sequencer.
// Writes are single-cycle strobes: a *_FLAG high for one clock qualifies its data in that cycle.
interface trig_seq_8p_if #(
  parameter int DUR_W = 32
);
  logic             iSET_DUR_FLAG;
  logic [2:0]       iSET_STEP;
  logic [DUR_W-1:0] iSET_DUR;
  logic             iSET_GAP_FLAG;
  logic [DUR_W-1:0] iSET_GAP;
  logic             iSET_NSTEP_FLAG;
  logic [3:0]       iSET_NSTEP;
  logic             iStart;
  logic             iAbort;
  logic             oIndexFlag;
  logic [7:0]       oIndex;
  logic             oTrigger;
  logic [2:0]       oStep;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       dbg_state;

  modport master (
    output iSET_DUR_FLAG, iSET_STEP, iSET_DUR, iSET_GAP_FLAG, iSET_GAP,
           iSET_NSTEP_FLAG, iSET_NSTEP, iStart, iAbort,
    input  oIndexFlag, oIndex, oTrigger, oStep, oBusy, oDone, dbg_state
  );

  modport slave (
    input  iSET_DUR_FLAG, iSET_STEP, iSET_DUR, iSET_GAP_FLAG, iSET_GAP,
           iSET_NSTEP_FLAG, iSET_NSTEP, iStart, iAbort,
    output oIndexFlag, oIndex, oTrigger, oStep, oBusy, oDone, dbg_state
  );
endinterface

// File: rtl/trig_seq_8p.sv
// Trigger sequencer: loads the code table index, then plays up to 8 programmed
// trigger pulses from slot nstep-1 down to 0, separated by a common gap.
module trig_seq_8p #(
  parameter int DUR_W     = 32,
  parameter int NSTEP_MAX = 8
) (
  input  logic         iClk,
  input  logic         iRst,
  trig_seq_8p_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_ON     = 3'd3,
    S_OFF    = 3'd4,
    S_TAIL   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       index_q, index_d;
  logic             flag_q, flag_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       sync_q, sync_d;
  logic [DUR_W-1:0] gap_q, gap_d;
  logic [3:0]       nstep_q, nstep_d;
  logic [DUR_W-1:0] dur_q [NSTEP_MAX];
  logic [DUR_W-1:0] dur_d [NSTEP_MAX];

  logic       start_edge;
  logic [2:0] last_slot;
  logic [2:0] prev_step;

  // sync_q[1] is the metastability-safe copy; sync_q[2] only exists for edge detect.
  assign sync_d     = {sync_q[1:0], bus.iStart};
  assign start_edge = sync_q[1] & ~sync_q[2];
  assign last_slot  = nstep_q[2:0] - 3'd1;
  assign prev_step  = step_q - 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    index_d = index_q;
    gap_d   = gap_q;
    nstep_d = nstep_q;
    dur_d   = dur_q;

    if (state_q == S_IDLE) begin
      if (bus.iSET_DUR_FLAG)
        dur_d[bus.iSET_STEP] = (bus.iSET_DUR == '0) ? DUR_W'(1) : bus.iSET_DUR;
      if (bus.iSET_GAP_FLAG)
        gap_d = (bus.iSET_GAP == '0) ? DUR_W'(1) : bus.iSET_GAP;
      if (bus.iSET_NSTEP_FLAG && (bus.iSET_NSTEP != 4'd0))
        nstep_d = (bus.iSET_NSTEP > 4'(NSTEP_MAX)) ? 4'(NSTEP_MAX) : bus.iSET_NSTEP;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge && !bus.iAbort) begin
          state_d = S_LOAD;
          step_d  = last_slot;
          index_d = {5'd0, last_slot};
        end
      end
      S_LOAD: state_d = S_SETTLE;
      S_SETTLE: begin
        state_d = S_ON;
        cnt_d   = dur_q[step_q];
      end
      S_ON: begin
        if (cnt_q == DUR_W'(1)) begin
          if (step_q == 3'd0) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_OFF;
            cnt_d   = gap_q;
          end
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      S_OFF: begin
        if (cnt_q == DUR_W'(1)) begin
          state_d = S_ON;
          step_d  = prev_step;
          cnt_d   = dur_q[prev_step];
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      S_TAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a start edge seen in the same cycle.
    if (bus.iAbort && (state_q != S_IDLE))
      state_d = S_IDLE;

    flag_d = (state_d == S_LOAD);
    trig_d = (state_d == S_ON);
    busy_d = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
             (state_d == S_ON)   || (state_d == S_OFF);
    done_d = (state_d == S_TAIL);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      index_q <= '0;
      flag_q  <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= '0;
      gap_q   <= DUR_W'(1);
      nstep_q <= 4'(NSTEP_MAX);
      for (int i = 0; i < NSTEP_MAX; i++) dur_q[i] <= DUR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      index_q <= index_d;
      flag_q  <= flag_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
      gap_q   <= gap_d;
      nstep_q <= nstep_d;
      dur_q   <= dur_d;
    end
  end

  assign bus.oIndexFlag = flag_q;
  assign bus.oIndex     = index_q;
  assign bus.oTrigger   = trig_q;
  assign bus.oStep      = step_q;
  assign bus.oBusy      = busy_q;
  assign bus.oDone      = done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_trig_seq_8p.sv
// Bench for trig_seq_8p: table-driven runs, directed corner sequences and random
// configurations, all scored cycle by cycle against a waveform model.
module tb_trig_seq_8p;
  localparam int W = 15;  // {flag, index[7:0], trig, step[2:0], busy, done}

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  trig_seq_8p_if #(.DUR_W(32)) bus ();
  trig_seq_8p #(.DUR_W(32), .NSTEP_MAX(8)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  // Reference register file, updated with the write rules as the bench writes.
  int m_nstep;
  int m_gap;
  int m_dur[8];

  int         got_busy;
  int         got_trig;
  logic [7:0] got_idx;

  typedef struct packed {
    logic [3:0]      nstep_wr;
    logic [7:0]      gap_wr;
    logic [7:0][7:0] dur_wr;
    logic [7:0]      exp_busy;
    logic [7:0]      exp_trig;
    logic [7:0]      exp_idx;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Index only matters while the flag is up, step only while the trigger is up.
  function automatic logic [W-1:0] pack_act();
    return {bus.oIndexFlag, bus.oIndexFlag ? bus.oIndex : 8'h00,
            bus.oTrigger, bus.oTrigger ? bus.oStep : 3'd0, bus.oBusy, bus.oDone};
  endfunction

  function automatic logic [W-1:0] pack_raw();
    return {bus.oIndexFlag, bus.oIndex, bus.oTrigger, bus.oStep, bus.oBusy, bus.oDone};
  endfunction

  function automatic void model_reset();
    m_nstep = 8;
    m_gap   = 1;
    foreach (m_dur[s]) m_dur[s] = 1;
  endfunction

  function automatic void push_rec(bit flag, int idx, bit trig, int step, bit busy, bit done);
    exp_q.push_back({flag, 8'(idx), trig, 3'(step), busy, done});
  endfunction

  // Expected per-cycle outputs, from the cycle after iStart rises to one idle cycle past oDone.
  function automatic void build_run();
    int s;
    exp_q.delete();
    push_rec(0, 0, 0, 0, 0, 0);
    push_rec(0, 0, 0, 0, 0, 0);
    push_rec(1, m_nstep - 1, 0, 0, 1, 0);
    push_rec(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < m_nstep; k++) begin
      s = m_nstep - 1 - k;
      repeat (m_dur[s]) push_rec(0, 0, 1, s, 1, 0);
      if (k < m_nstep - 1) repeat (m_gap) push_rec(0, 0, 0, 0, 1, 0);
    end
    push_rec(0, 0, 0, 0, 0, 1);
    push_rec(0, 0, 0, 0, 0, 0);
  endfunction

  task automatic wr_dur(input int s, input int v);
    @(negedge iClk);
    bus.iSET_DUR_FLAG = 1'b1;
    bus.iSET_STEP     = 3'(s);
    bus.iSET_DUR      = 32'(v);
    @(negedge iClk);
    bus.iSET_DUR_FLAG = 1'b0;
    m_dur[s] = (v == 0) ? 1 : v;
  endtask

  task automatic wr_gap(input int v);
    @(negedge iClk);
    bus.iSET_GAP_FLAG = 1'b1;
    bus.iSET_GAP      = 32'(v);
    @(negedge iClk);
    bus.iSET_GAP_FLAG = 1'b0;
    m_gap = (v == 0) ? 1 : v;
  endtask

  task automatic wr_nstep(input int v);
    @(negedge iClk);
    bus.iSET_NSTEP_FLAG = 1'b1;
    bus.iSET_NSTEP      = 4'(v);
    @(negedge iClk);
    bus.iSET_NSTEP_FLAG = 1'b0;
    if (v != 0) m_nstep = (v > 8) ? 8 : v;
  endtask

  // Plays one run and scores every cycle. abort_step >= 0 asserts iAbort during the
  // first ON cycle of that slot; disturb injects a second start edge and writes mid-run.
  task automatic run_check(input string name, input int abort_step, input bit disturb);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    int n;
    int abort_at;
    bit aborted;
    build_run();
    n        = exp_q.size();
    abort_at = -1;
    aborted  = 1'b0;
    if (abort_step >= 0)
      for (int i = 0; i < n; i++)
        if (abort_at < 0 && exp_q[i][5] && exp_q[i][4:2] == 3'(abort_step)) abort_at = i;
    got_busy = 0;
    got_trig = 0;
    got_idx  = 8'hff;
    @(negedge iClk);
    bus.iStart = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      exp_v = exp_q.pop_front();
      if (aborted) exp_v = '0;
      act_v = pack_act();
      check($sformatf("%s[%0d]", name, i), 32'(act_v), 32'(exp_v));
      if (bus.oBusy) got_busy++;
      if (bus.oTrigger) got_trig++;
      if (bus.oIndexFlag) got_idx = bus.oIndex;
      bus.iAbort = 1'b0;
      if (i == abort_at) begin
        bus.iAbort = 1'b1;
        aborted    = 1'b1;
      end
      if (i == 3) bus.iStart = 1'b0;
      if (disturb) begin
        if (i == 6) bus.iStart = 1'b1;
        if (i == 9) bus.iStart = 1'b0;
        if (i == 7) begin
          bus.iSET_DUR_FLAG = 1'b1; bus.iSET_STEP = 3'd2; bus.iSET_DUR = 32'd1;
          bus.iSET_GAP_FLAG = 1'b1; bus.iSET_GAP = 32'd1;
          bus.iSET_NSTEP_FLAG = 1'b1; bus.iSET_NSTEP = 4'd8;
        end
        if (i == 8) begin
          bus.iSET_DUR_FLAG = 1'b0; bus.iSET_GAP_FLAG = 1'b0; bus.iSET_NSTEP_FLAG = 1'b0;
        end
      end
    end
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
  endtask

  initial begin
    int idle_busy;
    bit seen_trig;
    bit found;

    vecs[0] = '{nstep_wr: 4'd8,  gap_wr: 8'd1, dur_wr: {8{8'd1}},
                exp_busy: 8'd17, exp_trig: 8'd8,  exp_idx: 8'd7};
    vecs[1] = '{nstep_wr: 4'd3,  gap_wr: 8'd3,
                dur_wr: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd2, 8'd4},
                exp_busy: 8'd19, exp_trig: 8'd11, exp_idx: 8'd2};
    vecs[2] = '{nstep_wr: 4'd12, gap_wr: 8'd0, dur_wr: {8{8'd2}},
                exp_busy: 8'd25, exp_trig: 8'd16, exp_idx: 8'd7};
    vecs[3] = '{nstep_wr: 4'd1,  gap_wr: 8'd9,
                dur_wr: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0},
                exp_busy: 8'd3,  exp_trig: 8'd1,  exp_idx: 8'd0};
    vecs[4] = '{nstep_wr: 4'd0,  gap_wr: 8'd4,
                dur_wr: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3},
                exp_busy: 8'd5,  exp_trig: 8'd3,  exp_idx: 8'd0};
    vecs[5] = '{nstep_wr: 4'd2,  gap_wr: 8'd0,
                dur_wr: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd6, 8'd0},
                exp_busy: 8'd10, exp_trig: 8'd7,  exp_idx: 8'd1};

    bus.iSET_DUR_FLAG = 1'b0; bus.iSET_STEP = '0; bus.iSET_DUR = '0;
    bus.iSET_GAP_FLAG = 1'b0; bus.iSET_GAP = '0;
    bus.iSET_NSTEP_FLAG = 1'b0; bus.iSET_NSTEP = '0;
    bus.iStart = 1'b0; bus.iAbort = 1'b0;
    iRst = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge iClk);
    check("reset_outputs", 32'(pack_raw()), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);
    iRst = 1'b1;

    // Default registers: 8 single-cycle pulses, 17 busy cycles.
    run_check("default", -1, 1'b0);
    check("default_busy", got_busy, 17);
    check("default_idx", 32'(got_idx), 32'd7);

    // Table-driven configurations.
    for (int v = 0; v < 6; v++) begin
      wr_nstep(int'(vecs[v].nstep_wr));
      wr_gap(int'(vecs[v].gap_wr));
      for (int s = 0; s < 8; s++) wr_dur(s, int'(vecs[v].dur_wr[s]));
      run_check($sformatf("vec%0d", v), -1, 1'b0);
      check($sformatf("vec%0d_busy", v), got_busy, int'(vecs[v].exp_busy));
      check($sformatf("vec%0d_trig", v), got_trig, int'(vecs[v].exp_trig));
      check($sformatf("vec%0d_idx", v), 32'(got_idx), 32'(vecs[v].exp_idx));
    end

    // Second start edge and writes during a run are dropped.
    wr_nstep(3); wr_gap(3); wr_dur(0, 4); wr_dur(1, 2); wr_dur(2, 5);
    run_check("disturb", -1, 1'b1);
    idle_busy = 0;
    repeat (10) begin
      @(negedge iClk);
      if (bus.oBusy) idle_busy++;
    end
    check("no_second_run", idle_busy, 0);
    run_check("after_disturb", -1, 1'b0);
    check("after_disturb_trig", got_trig, 11);

    // Abort during the second ON of a 4-step run, then a clean rerun.
    wr_nstep(4);
    for (int s = 0; s < 4; s++) wr_dur(s, $urandom_range(1, 4));
    wr_gap($urandom_range(1, 3));
    run_check("abort", 2, 1'b0);
    run_check("post_abort", -1, 1'b0);
    check("post_abort_idx", 32'(got_idx), 32'd3);

    // Random configurations.
    for (int r = 0; r < 8; r++) begin
      wr_nstep($urandom_range(0, 15));
      wr_gap($urandom_range(0, 3));
      for (int s = 0; s < 8; s++)
        if ($urandom_range(0, 1) == 1) wr_dur(s, $urandom_range(0, 5));
      run_check($sformatf("rand%0d", r), -1, 1'b0);
    end

    // Reset asserted during a gap: outputs clear immediately, registers return to defaults.
    wr_nstep(2); wr_dur(0, 2); wr_dur(1, 2); wr_gap(6);
    @(negedge iClk);
    bus.iStart = 1'b1;
    seen_trig = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge iClk);
      if (i == 3) bus.iStart = 1'b0;
      if (bus.oTrigger) seen_trig = 1'b1;
      else if (seen_trig && bus.oBusy) found = 1'b1;
    end
    bus.iStart = 1'b0;
    check("reach_off", 32'(found), 32'd1);
    #2 iRst = 1'b0;
    #1;
    check("async_reset_outputs", 32'(pack_raw()), 32'd0);
    check("async_reset_state", 32'(bus.dbg_state), 32'd0);
    @(negedge iClk);
    iRst = 1'b1;
    model_reset();
    run_check("post_reset", -1, 1'b0);
    check("post_reset_busy", got_busy, 17);
    check("post_reset_trig", got_trig, 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
